// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one start/busy sequential signed multiplier
// between two requesters, with a watchdog for a multiplier that never goes busy.
module mult_arbiter #(
    parameter int unsigned MBITS = 12,
    parameter int unsigned NBITS = 8,
    parameter int unsigned TMO   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic [MBITS-1:0]       mpd0,
    input  logic [NBITS-1:0]       mpr0,
    output logic                   gnt0,
    output logic                   done0,
    input  logic                   req1,
    input  logic [MBITS-1:0]       mpd1,
    input  logic [NBITS-1:0]       mpr1,
    output logic                   gnt1,
    output logic                   done1,
    output logic [MBITS+NBITS-1:0] prod_out,
    output logic                   err,
    output logic                   arb_busy,
    output logic                   m_start,
    output logic [MBITS-1:0]       m_mpd,
    output logic [NBITS-1:0]       m_mpr,
    input  logic [MBITS+NBITS-1:0] m_prod,
    input  logic                   m_busy
);
    localparam int unsigned CBITS = $clog2(TMO);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    state_t           state;
    logic             owner;
    logic             last;
    logic [CBITS-1:0] count;
    logic             win_c;

    // On contention the requester that did not win last time is served.
    assign win_c = (req0 && req1) ? ~last : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            count    <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            prod_out <= '0;
            err      <= 1'b0;
            arb_busy <= 1'b0;
            m_start  <= 1'b0;
            m_mpd    <= '0;
            m_mpr    <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;
            m_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        if (win_c) begin
                            m_mpd <= mpd1;
                            m_mpr <= mpr1;
                            gnt1  <= 1'b1;
                        end else begin
                            m_mpd <= mpd0;
                            m_mpr <= mpr0;
                            gnt0  <= 1'b1;
                        end
                        m_start  <= 1'b1;
                        owner    <= win_c;
                        last     <= win_c;
                        count    <= '0;
                        arb_busy <= 1'b1;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (m_busy) begin
                        state <= WAIT_LO;
                    end else if (count == CBITS'(TMO - 1)) begin
                        // Watchdog: report a zero product with err and release the owner.
                        prod_out <= '0;
                        done0    <= ~owner;
                        done1    <= owner;
                        err      <= 1'b1;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        count <= count + CBITS'(1);
                    end
                end
                WAIT_LO: begin
                    if (!m_busy) begin
                        prod_out <= m_prod;
                        done0    <= ~owner;
                        done1    <= owner;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural start/busy signed multiplier.
module tb_mult_arbiter;
    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [11:0] mpd0, mpd1;
    logic [7:0]  mpr0, mpr1;
    logic        gnt0, gnt1, done0, done1;
    logic [19:0] prod_out;
    logic        err, arb_busy, m_start;
    logic [11:0] m_mpd;
    logic [7:0]  m_mpr;
    logic [19:0] m_prod;
    logic        m_busy;

    int passed = 0;
    int total  = 0;
    int cyc;
    int snap;
    int n_side1 = 0;
    int n_done  = 0;
    logic mdl_en;
    int ph;

    mult_arbiter #(.MBITS(12), .NBITS(8), .TMO(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .mpd0(mpd0), .mpr0(mpr0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .mpd1(mpd1), .mpr1(mpr1), .gnt1(gnt1), .done1(done1),
        .prod_out(prod_out), .err(err), .arb_busy(arb_busy),
        .m_start(m_start), .m_mpd(m_mpd), .m_mpr(m_mpr),
        .m_prod(m_prod), .m_busy(m_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] smul(input logic [11:0] a, input logic [7:0] b);
        logic signed [19:0] sa, sb;
        sa = {{8{a[11]}}, a};
        sb = {{12{b[7]}}, b};
        return 20'(sa * sb);
    endfunction

    // Multiplier model: busy rises 2 cycles after start and stays high 10 cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph <= 0; m_busy <= 1'b0; m_prod <= '0;
        end else if (m_start) begin
            ph <= mdl_en ? 1 : 0; m_busy <= 1'b0; m_prod <= smul(m_mpd, m_mpr);
        end else if (ph != 0) begin
            ph <= (ph == 11) ? 0 : ph + 1;
            m_busy <= (ph <= 10);
        end
    end

    always @(posedge clk) begin
        if (gnt1 || done1) n_side1 <= n_side1 + 1;
        if (done0 || done1) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done0 || done1) && n < max);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        clk = 0; reset = 0; mdl_en = 1'b1;
        req0 = 0; req1 = 0; mpd0 = '0; mpr0 = '0; mpd1 = '0; mpr1 = '0;
        #2 do_reset();

        // 1: reset state, then single req0 service
        chk("rst_arb_busy", 32'(arb_busy), 0);
        chk("rst_pulses", 32'({gnt0, gnt1, done0, done1, err, m_start}), 0);
        chk("rst_prod", 32'(prod_out), 0);
        chk("rst_m_mpd", 32'(m_mpd), 0);
        snap = n_side1;
        req0 = 1; mpd0 = 12'h100; mpr0 = 8'h40;
        @(negedge clk);
        chk("t1_gnt0", 32'(gnt0), 1);
        chk("t1_m_start", 32'(m_start), 1);
        chk("t1_m_mpd", 32'(m_mpd), 32'h100);
        chk("t1_m_mpr", 32'(m_mpr), 32'h40);
        chk("t1_arb_busy", 32'(arb_busy), 1);
        req0 = 0;
        @(negedge clk);
        chk("t1_pulse_end", 32'({gnt0, m_start}), 0);
        wait_done(40, cyc);
        chk("t1_latency", 32'(cyc + 1), 13);
        chk("t1_done0", 32'({done0, done1, err}), 32'b100);
        chk("t1_prod", 32'(prod_out), 32'h04000);
        @(negedge clk);
        chk("t1_idle", 32'({arb_busy, done0}), 0);
        chk("t1_no_side1", 32'(n_side1 - snap), 0);

        // 2: negative multiplicand
        req0 = 1; mpd0 = 12'hB00; mpr0 = 8'h40;
        @(negedge clk);
        chk("t2_gnt0", 32'(gnt0), 1);
        req0 = 0;
        wait_done(40, cyc);
        chk("t2_done0", 32'(done0), 1);
        chk("t2_prod", 32'(prod_out), 32'hEC000);

        // 6: operand change after grant is ignored
        req0 = 1; mpd0 = 12'h123; mpr0 = 8'h05;
        @(negedge clk);
        chk("t6_gnt0", 32'(gnt0), 1);
        req0 = 0;
        @(negedge clk);
        mpd0 = 12'hFFF;
        @(negedge clk);
        chk("t6_m_mpd_held", 32'(m_mpd), 32'h123);
        wait_done(40, cyc);
        chk("t6_done0", 32'(done0), 1);
        chk("t6_prod", 32'(prod_out), 32'h005AF);

        // 4: multiplier never raises busy -> watchdog
        mdl_en = 1'b0;
        req0 = 1; mpd0 = 12'h055; mpr0 = 8'h11;
        @(negedge clk);
        chk("t4_gnt0", 32'(gnt0), 1);
        req0 = 0;
        wait_done(40, cyc);
        chk("t4_latency", 32'(cyc), 8);
        chk("t4_done_err", 32'({done0, done1, err}), 32'b101);
        chk("t4_prod", 32'(prod_out), 0);
        @(negedge clk);
        chk("t4_after", 32'({arb_busy, err, done0}), 0);
        mdl_en = 1'b1;

        // 3: simultaneous requests alternate, starting with req0 after reset
        do_reset();
        req0 = 1; mpd0 = 12'h010; mpr0 = 8'h02;
        req1 = 1; mpd1 = 12'h7FF; mpr1 = 8'h80;
        @(negedge clk);
        chk("t3_first_gnt", 32'({gnt0, gnt1}), 32'b10);
        wait_done(40, cyc);
        chk("t3_done0", 32'({done0, done1}), 32'b10);
        chk("t3_prod0", 32'(prod_out), 32'h00020);
        @(negedge clk);
        chk("t3_second_gnt", 32'({gnt0, gnt1}), 32'b01);
        wait_done(40, cyc);
        chk("t3_done1", 32'({done0, done1}), 32'b01);
        chk("t3_prod1", 32'(prod_out), 32'hC0080);
        @(negedge clk);
        chk("t3_third_gnt", 32'({gnt0, gnt1}), 32'b10);
        req0 = 0; req1 = 0;
        wait_done(40, cyc);
        chk("t3_done0_again", 32'({done0, done1}), 32'b10);

        // 5: async reset in WAIT_LO aborts without done
        @(negedge clk);
        req0 = 1; mpd0 = 12'h020; mpr0 = 8'h03;
        @(negedge clk);
        chk("t5_gnt0", 32'(gnt0), 1);
        req0 = 0;
        repeat (4) @(negedge clk);
        chk("t5_in_wait_lo", 32'({arb_busy, m_busy}), 32'b11);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_busy", 32'(arb_busy), 0);
        chk("t5_async_regs", 32'({m_mpd, m_mpr}), 0);
        chk("t5_async_prod", 32'(prod_out), 0);
        @(negedge clk);
        reset = 1'b0;
        snap = n_done;
        repeat (20) @(negedge clk);
        chk("t5_no_done", 32'(n_done - snap), 0);
        req1 = 1; mpd1 = 12'h003; mpr1 = 8'hFF;
        @(negedge clk);
        chk("t5_gnt1", 32'({gnt0, gnt1}), 32'b01);
        req1 = 0;
        wait_done(40, cyc);
        chk("t5_done1", 32'({done0, done1}), 32'b01);
        chk("t5_prod", 32'(prod_out), 32'hFFFFD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential signed multiplier (12-bit multiplicand × 8-bit multiplier → 20-bit product, start/busy interface) between two requesters.
- Captures the winner's operands, pulses the multiplier start, tracks busy, and returns the product to the owner with a done pulse.
- A watchdog recovers if the multiplier never asserts busy.

Parameters:
- MBITS, 12, multiplicand width (two's complement)
- NBITS, 8, multiplier width (two's complement)
- TMO, 8, cycles allowed in WAIT_HI for m_busy to rise before timeout (≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 request; level, held until gnt0
- mpd0  in  MBITS  requester 0 multiplicand; stable while req0 high and not yet granted
- mpr0  in  NBITS  requester 0 multiplier
- gnt0  out  1  one-cycle pulse: requester 0 operands captured
- done0  out  1  one-cycle pulse: result for requester 0 on prod_out
- req1, mpd1, mpr1, gnt1, done1  same as above for requester 1
- prod_out  out  MBITS+NBITS  result register, valid in the done cycle, held until the next done
- err  out  1  one-cycle pulse with done on watchdog timeout
- arb_busy  out  1  high whenever state ≠ IDLE
- m_start  out  1  multiplier start pulse
- m_mpd  out  MBITS  multiplicand to multiplier, registered
- m_mpr  out  NBITS  multiplier operand to multiplier, registered
- m_prod  in  MBITS+NBITS  multiplier product
- m_busy  in  1  multiplier busy

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; owner=0; last=1, so req0 wins first; watchdog count=0. No done is issued for an aborted operation.
- All outputs are registered. gnt*, done*, err and m_start are single-cycle pulses.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, it wins.
  - If both are high, the winner is the requester ≠ last.
  - Next edge: m_mpd/m_mpr ← winner operands; gnt_w=1; m_start=1; owner=last=w; count=0; state→WAIT_HI.
- WAIT_HI:
  - gnt and m_start return to 0.
  - If m_busy=1: state→WAIT_LO.
  - Else count++. When count reaches TMO-1: prod_out←0, done_owner=1, err=1, state→IDLE.
- WAIT_LO:
  - While m_busy=1: hold.
  - When m_busy=0: prod_out←m_prod, done_owner=1, state→IDLE.
- m_mpd/m_mpr hold their values until the next grant. A requester's operand changes after its gnt have no effect.
- From IDLE, the next grant can be issued in the cycle after done, giving back-to-back service.
- A req still high after its own done counts as a new request.
- Loser fairness: a requester that loses arbitration is served next, so it waits at most one operation.
- Request arriving in the done cycle: it is sampled in IDLE on the following cycle.
- Width: prod_out is MBITS+NBITS bits, passed through with no truncation and no fixed-point shift; scaling is the consumer's job.
- Latency: the req sampled at edge k gives gnt and m_start at k+1. done arrives one cycle after the edge where m_busy is sampled low in WAIT_LO.

Test Plan:
1. Reset, then req0 only with mpd0=12'h100, mpr0=8'h40; model asserts busy 2 cycles after start and holds it 10 cycles → gnt0 and m_start one cycle after req, m_mpd=12'h100, done0 with prod_out=20'h04000, err=0, gnt1/done1 never asserted.
2. req0 with mpd0=12'hB00, mpr0=8'h40 → prod_out=20'hEC000 (−81920) on done0.
3. req0 and req1 asserted in the same cycle, both held through service → first grant gnt0 (last=1 after reset), then gnt1 immediately after done0, then gnt0 again; each done pulses only for its owner.
4. Multiplier model never raises busy → after TMO cycles in WAIT_HI: done0=1, err=1, prod_out=0, arb_busy=0 the cycle after.
5. Assert reset mid-WAIT_LO → all outputs 0 immediately (asynchronous); no done for the aborted operation; next req1 alone is granted.
6. Change mpd0 to 12'hFFF one cycle after gnt0 → m_mpd stays at the captured value and the product reflects the original operands.
